// File: rtl/instr_block_memory.sv
// Block-refill instruction memory: fixed access latency, then four word beats
// assembled into a 128-bit line. A side port preloads words while idle.
module instr_block_memory #(
  parameter int LATENCY     = 5,
  parameter int DEPTH_WORDS = 256
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         read,
  input  logic [5:0]   address,
  output logic         busywait,
  output logic [127:0] readinst,
  input  logic         load_en,
  input  logic [7:0]   load_addr,
  input  logic [31:0]  load_data
);

  typedef enum logic [1:0] {IDLE, WAIT, BEAT, DONE} state_t;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [1:0]   beat_q, beat_d;
  logic [5:0]   blk_q, blk_d;
  logic [127:0] readinst_q;

  logic [31:0]  mem [DEPTH_WORDS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      beat_q  <= 2'd0;
      blk_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      blk_q   <= blk_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    blk_d    = blk_q;
    busywait = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Stall is visible in the request cycle itself.
        busywait = read;
        if (read) begin
          blk_d   = address;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        busywait = 1'b1;
        if (cnt_q == 8'd0) begin
          beat_d  = 2'd0;
          state_d = BEAT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      BEAT: begin
        busywait = 1'b1;
        beat_d   = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage is deliberately not reset; loads only land while idle.
  always_ff @(posedge clock) begin
    if (load_en && (state_q == IDLE)) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      readinst_q <= 128'd0;
    end else if (state_q == BEAT) begin
      readinst_q[32*beat_q +: 32] <= mem[{blk_q, beat_q}];
    end
  end

  assign readinst = readinst_q;

endmodule

// File: tb/tb_instr_block_memory.sv
// Directed bench: table of fetch scenarios on a LATENCY=5 instance, plus
// hand sequences for reset abort and LATENCY=1 back-to-back requests.
module tb_instr_block_memory;

  logic         clock = 1'b0;
  logic         reset;
  logic         read, read1;
  logic [5:0]   address, address1;
  logic         busywait, busywait1;
  logic [127:0] readinst, readinst1;
  logic         load_en;
  logic [7:0]   load_addr;
  logic [31:0]  load_data;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  instr_block_memory #(.LATENCY(5), .DEPTH_WORDS(256)) dut (
    .clock(clock), .reset(reset), .read(read), .address(address),
    .busywait(busywait), .readinst(readinst),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  instr_block_memory #(.LATENCY(1), .DEPTH_WORDS(256)) dut1 (
    .clock(clock), .reset(reset), .read(read1), .address(address1),
    .busywait(busywait1), .readinst(readinst1),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  typedef struct {
    string        name;
    logic [5:0]   addr;
    int           chg_at;
    logic [5:0]   addr2;
    int           drop_at;
    int           ld_at;
    logic [7:0]   ld_addr;
    logic [31:0]  ld_data;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] BLK4 = {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
  localparam logic [127:0] BLK7 = {32'hB0000003, 32'hB0000002, 32'hB0000001, 32'hB0000000};
  localparam logic [127:0] BLK0 = {32'hC0000003, 32'hC0000002, 32'hC0000001, 32'hC0000000};
  localparam logic [127:0] BLK4D = {32'hA0000003, 32'hDEADBEEF, 32'hA0000001, 32'hA0000000};

  vec_t vecs [7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  task automatic load_word(input logic [7:0] a, input logic [31:0] d);
    @(posedge clock); #1;
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clock); #1;
    load_en = 1'b0;
  endtask

  // Waits for busywait to fall on dut; returns edge index relative to E0 (k=0).
  task automatic wait_done(output int k_done);
    k_done = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (!busywait) begin
        k_done = k;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int k_done;
    @(posedge clock); #1;
    read = 1'b1; address = v.addr;
    if (v.ld_at == 0) begin
      load_en = 1'b1; load_addr = v.ld_addr; load_data = v.ld_data;
    end
    #1 check({v.name, "_busy_req"}, 128'(busywait), 128'd1);
    @(posedge clock); #1;   // edge E0
    k_done = -1;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin
        @(posedge clock); #1;
        if (!busywait) begin
          k_done = k;
          break;
        end
      end
      load_en = 1'b0;
      if (k + 1 == v.chg_at)  address = v.addr2;
      if (k + 1 == v.drop_at) read = 1'b0;
      if (k + 1 == v.ld_at) begin
        load_en = 1'b1; load_addr = v.ld_addr; load_data = v.ld_data;
      end
    end
    load_en = 1'b0;
    check({v.name, "_done_edge"}, 128'(k_done), 128'd9);
    check({v.name, "_data"}, readinst, v.exp);
    read = 1'b0;
    @(posedge clock); #1;
    check({v.name, "_idle_after"}, 128'(busywait), 128'd0);
  endtask

  initial begin
    int k_done;
    int e_first, e_second;

    vecs[0] = '{"basic",     6'd4, -1, 6'd0, -1, -1, 8'h00, 32'h0,        BLK4};
    vecs[1] = '{"addr_hold", 6'd4,  1, 6'd7, -1, -1, 8'h00, 32'h0,        BLK4};
    vecs[2] = '{"read_drop", 6'd4, -1, 6'd0,  2, -1, 8'h00, 32'h0,        BLK4};
    vecs[3] = '{"load_busy", 6'd4, -1, 6'd0, -1,  3, 8'h11, 32'h55555555, BLK4};
    vecs[4] = '{"refetch4",  6'd4, -1, 6'd0, -1, -1, 8'h00, 32'h0,        BLK4};
    vecs[5] = '{"sim_load",  6'd4, -1, 6'd0, -1,  0, 8'h12, 32'hDEADBEEF, BLK4D};
    vecs[6] = '{"fetch0",    6'd0, -1, 6'd0, -1, -1, 8'h00, 32'h0,        BLK0};

    reset = 1'b0; read = 1'b0; read1 = 1'b0; address = 6'd0; address1 = 6'd0;
    load_en = 1'b0; load_addr = 8'd0; load_data = 32'd0;
    #12;
    check("reset_readinst", readinst, 128'd0);
    check("reset_busy", 128'(busywait), 128'd0);
    reset = 1'b1;

    for (int i = 0; i < 4; i++) begin
      load_word(8'h10 + 8'(i), 32'hA0000000 + i);
      load_word(8'h1C + 8'(i), 32'hB0000000 + i);
      load_word(8'h00 + 8'(i), 32'hC0000000 + i);
    end

    // LATENCY=1: DONE at E0+5, second request accepted in the IDLE cycle after.
    @(posedge clock); #1;
    read1 = 1'b1; address1 = 6'd4;
    e_first = -1; e_second = -1;
    for (int k = 0; k <= 40; k++) begin
      @(posedge clock); #1;
      if (k > 0 && !busywait1) begin
        if (e_first < 0) begin
          e_first = k;
          check("lat1_data_a", readinst1, BLK4);
          read1 = 1'b0;
          @(posedge clock); #1; k++;
          read1 = 1'b1; address1 = 6'd7;
        end else begin
          e_second = k;
          break;
        end
      end
    end
    read1 = 1'b0;
    check("lat1_done_edge", 128'(e_first), 128'd5);
    check("lat1_spacing", 128'(e_second - e_first), 128'd7);
    check("lat1_data_b", readinst1, BLK7);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset mid-WAIT aborts; released with read high restarts a request.
    @(posedge clock); #1;
    read = 1'b1; address = 6'd7;
    @(posedge clock); @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    #1 check("rst_mid_readinst", readinst, 128'd0);
    #2 reset = 1'b1;
    #1 check("rst_release_busy", 128'(busywait), 128'd1);
    @(posedge clock); #1;   // new E0
    wait_done(k_done);
    check("rst_reissue_edge", 128'(k_done), 128'd9);
    check("rst_reissue_data", readinst, BLK7);
    read = 1'b0;
    @(posedge clock); #1;
    check("rst_idle_after", 128'(busywait), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_block_memory.md
# instr_block_memory

Backing instruction memory that serves 128-bit block refills to the instruction cache. It accepts a 6-bit block address with a level read request. It models a fixed access latency followed by a 4-beat word transfer, holding busywait high until the full block is assembled on readinst. A side load port preloads program words before or between fetches.

## Interface
Parameters:
- LATENCY, 5: wait cycles before the first beat; legal range 1..255.
- DEPTH_WORDS, 256: storage size in 32-bit words. Fixed at 64 blocks × 4 words.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low; clears control state.
- read  in  1  block read request, level; held by the cache until busywait falls.
- address  in  6  block address {tag[2:0], index[2:0]}.
- busywait  out  1  high while a request is pending or in progress.
- readinst  out  128  assembled block; word n (n=0..3) on bits [32n+31:32n].
- load_en  in  1  program-load strobe.
- load_addr  in  8  word address for load.
- load_data  in  32  word written on load.

## Operation
- Storage: 256 × 32-bit words. Block b occupies word addresses {b, 2'd0}..{b, 2'd3}. Storage is not cleared by reset.
- State machine: IDLE, WAIT, BEAT, DONE.
- IDLE:
  - busywait = read, combinationally, so the cache sees the stall in the request cycle.
  - At an edge with read=1: latch address into blk, set cnt = LATENCY-1, move to WAIT.
- WAIT:
  - busywait=1.
  - At each edge: if cnt==0, set beat=0 and move to BEAT; otherwise decrement cnt.
- BEAT:
  - busywait=1.
  - At each edge: readinst[32·beat +: 32] ← mem[{blk, beat}], then increment beat.
  - After the beat==3 capture, move to DONE.
- DONE:
  - busywait=0 and readinst holds the complete block.
  - Next edge moves to IDLE unconditionally.
- address changes after acceptance are ignored; the latched blk is used.
- Deasserting read mid-request does not abort it. The block still completes and passes through DONE.
- If read is still high in the IDLE cycle after DONE, it is a new request. The cache must drop read in DONE.
- Load port:
  - At an edge with load_en=1 and state==IDLE: mem[load_addr] ← load_data.
  - load_en in any other state is ignored. It is never queued.
- Simultaneous load and read in IDLE: both take effect at the same edge. A load to the requested block is visible in the returned data, because beats read later.
- readinst keeps the last completed block until the next request's BEAT cycles overwrite it. Its contents during BEAT are undefined for consumers.

## Timing
- Reset (reset=0, asynchronous) sets:
  - state=IDLE, cnt=0, beat=0, blk=0;
  - readinst=128'd0;
  - busywait=0, or equal to read once reset is released in IDLE.
- Reset asserted mid-request aborts it: next state is IDLE and no DONE is produced. The cache must reissue.
- Request accepted at edge E0 gives:
  - WAIT during cycles E0..E0+LATENCY-1;
  - BEAT during E0+LATENCY..E0+LATENCY+3;
  - DONE from edge E0+LATENCY+4 for one cycle.
- busywait is high from the cycle read first rises, including the pre-E0 cycle, through edge E0+LATENCY+4. It falls with entry to DONE.
- Back-to-back requests: minimum spacing is LATENCY+6 edges (DONE plus one IDLE cycle).
- cnt width is 8 bits; beat width is 2 bits and wraps naturally but never passes 3.

## Test plan
- Reset: assert reset=0 mid-WAIT with read=1 -> state IDLE, readinst=0, no DONE. After release, busywait=1 again in the same cycle (read still high).
- Basic fetch: load words 0x10..0x13 with 0xA0000000+i, then read address 6'd4 with LATENCY=5. Required response:
  - busywait high from the request cycle through edge E0+9;
  - at E0+9, readinst = {0xA0000003, 0xA0000002, 0xA0000001, 0xA0000000} with busywait=0.
- Address hold: change address to 6'd7 one cycle after E0 -> block 4 data still returned.
- Read drop: deassert read at E0+2 -> DONE still occurs at E0+9 with block 4 data; the next IDLE stays idle.
- Load during busy: load_en at E0+3 to word 0x11 -> memory unchanged; a re-fetch of block 4 returns the original 0xA0000001.
- Simultaneous load and read in IDLE: load 0x12 ← 0xDEADBEEF at the same edge as a read of block 4 -> returned word 2 = 0xDEADBEEF.
- LATENCY=1 variant: DONE at E0+5; two back-to-back requests complete 7 edges apart.
